mem_stage_hs: RTL and testbench

Parametrised successor to the pipeline memory stage. It executes loads and stores against an external data memory over a req/ack handshake, and stalls the pipeline until the access completes. It supports byte, halfword and word accesses with sign/zero extension, store byte-enables, misalignment detection and a bus-timeout error. It sits between the EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_stage_hs.sv | 200 ++++++++++++++++++++
 tb/tb_mem_stage_hs.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_hs.sv
// Pipeline memory stage: runs loads and stores against a req/ack data memory and stalls the pipeline until each access finishes.
// Handles byte/half/word sizing, sign/zero extension, misalignment rejection and a bus timeout.
module mem_stage_hs #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_m,
   input  logic [6:0]        control_m_i,
   input  logic [ADDR_W-1:0] alu_result_m,
   input  logic [31:0]       mem_write_data_m,
   output logic [1:0]        control_m_o,
   output logic [31:0]       mem_read_data_m,
   output logic              stall_m,
   output logic              misalign_m,
   output logic              bus_err_m,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ack
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       rdata_q;
   logic              bus_err_q;
   logic              req_q;
   logic              we_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [1:0]        lane_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;

   logic       reg_we;
   logic       sel;
   logic       mem_we;
   logic       mem_re;
   logic [1:0] size;
   logic       unsigned_ld;
   logic [1:0] lane;
   logic       access;
   logic       bad_align;
   logic       start;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;

   assign {reg_we, sel, mem_we, mem_re, size, unsigned_ld} = control_m_i;
   assign lane   = alu_result_m[1:0];
   assign access = valid_m & (mem_we | mem_re);

   // Size 11 has no defined access width, so it is rejected like any misaligned access.
   always_comb begin
      bad_align = 1'b1;
      unique case (size)
         2'b00:   bad_align = 1'b0;
         2'b01:   bad_align = lane[0];
         2'b10:   bad_align = (lane != 2'b00);
         default: bad_align = 1'b1;
      endcase
   end

   assign misalign_m = (state == IDLE) & access & bad_align;
   assign start      = (state == IDLE) & access & ~bad_align;

   always_comb begin
      be_next    = 4'b1111;
      wdata_next = mem_write_data_m;
      unique case (size)
         2'b00: begin
            be_next    = 4'b0001 << lane;
            wdata_next = {4{mem_write_data_m[7:0]}};
         end
         2'b01: begin
            be_next    = lane[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{mem_write_data_m[15:0]}};
         end
         default: begin
            be_next    = 4'b1111;
            wdata_next = mem_write_data_m;
         end
      endcase
   end

   function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  ln,
                                                input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      unique case (ln)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = ln[1] ? word[31:16] : word[15:0];
      unique case (sz)
         2'b00:   res = uns ? {24'b0, b} : {{24{b[7]}}, b};
         2'b01:   res = uns ? {16'b0, h} : {{16{h[15]}}, h};
         default: res = word;
      endcase
      return res;
   endfunction

   // Request-side values are frozen at the IDLE->REQ edge so the bus sees stable signals until ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         rdata_q   <= '0;
         bus_err_q <= 1'b0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         size_q    <= 2'b00;
         uns_q     <= 1'b0;
         lane_q    <= 2'b00;
         addr_q    <= '0;
         be_q      <= 4'b0000;
         wdata_q   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt       <= '0;
               bus_err_q <= 1'b0;
               if (start) begin
                  state   <= REQ;
                  req_q   <= 1'b1;
                  we_q    <= mem_we;
                  size_q  <= size;
                  uns_q   <= unsigned_ld;
                  lane_q  <= lane;
                  addr_q  <= {alu_result_m[ADDR_W-1:2], 2'b00};
                  be_q    <= be_next;
                  wdata_q <= wdata_next;
               end
            end
            REQ: begin
               if (dmem_ack) begin
                  state   <= DONE;
                  req_q   <= 1'b0;
                  rdata_q <= we_q ? 32'h0 : extract_load(dmem_rdata, size_q, lane_q, uns_q);
               end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
                  state     <= DONE;
                  req_q     <= 1'b0;
                  bus_err_q <= 1'b1;
                  rdata_q   <= 32'h0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               cnt   <= '0;
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   assign dmem_req   = req_q;
   assign dmem_we    = req_q & we_q;
   assign dmem_addr  = addr_q;
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;

   assign stall_m         = ~rst & (start | (state == REQ));
   assign mem_read_data_m = (state == DONE) ? rdata_q : 32'h0;
   assign bus_err_m       = (state == DONE) & bus_err_q;

   // Register write is suppressed while stalled so the MEM/WB register never sees a half-finished load.
   always_comb begin
      control_m_o = 2'b00;
      unique case (state)
         IDLE:    control_m_o = {reg_we & ~misalign_m & ~start, sel};
         REQ:     control_m_o = {1'b0, sel};
         DONE:    control_m_o = {reg_we & ~bus_err_q, sel};
         default: control_m_o = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Self-checking bench for mem_stage_hs: acts as the data memory and scores each instruction when its stall ends.
module tb_mem_stage_hs;

   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              valid_m;
   logic [6:0]        control_m_i;
   logic [ADDR_W-1:0] alu_result_m;
   logic [31:0]       mem_write_data_m;
   logic [1:0]        control_m_o;
   logic [31:0]       mem_read_data_m;
   logic              stall_m;
   logic              misalign_m;
   logic              bus_err_m;
   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [3:0]        dmem_be;
   logic [31:0]       dmem_wdata;
   logic [31:0]       dmem_rdata;
   logic              dmem_ack;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  ctrl;
      logic        err;
      logic        mis;
      int          stalls;
   } exp_t;

   exp_t sb[$];

   mem_stage_hs #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk              (clk),
      .rst              (rst),
      .valid_m          (valid_m),
      .control_m_i      (control_m_i),
      .alu_result_m     (alu_result_m),
      .mem_write_data_m (mem_write_data_m),
      .control_m_o      (control_m_o),
      .mem_read_data_m  (mem_read_data_m),
      .stall_m          (stall_m),
      .misalign_m       (misalign_m),
      .bus_err_m        (bus_err_m),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_addr        (dmem_addr),
      .dmem_be          (dmem_be),
      .dmem_wdata       (dmem_wdata),
      .dmem_rdata       (dmem_rdata),
      .dmem_ack         (dmem_ack)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one instruction, plays memory (ack after 'waits' REQ cycles) and scores the cycle where stall drops.
   task automatic applyStimulus(input string tag, input logic v, input logic [6:0] ctrl,
                                input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                                input int waits, input logic [31:0] exp_data, input logic [1:0] exp_ctrl,
                                input logic exp_err, input logic exp_mis, input int exp_stalls,
                                input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      exp_t e;
      int   stalls;
      int   reqs;
      bit   done;
      @(posedge clk);
      #1;
      valid_m          = v;
      control_m_i      = ctrl;
      alu_result_m     = addr;
      mem_write_data_m = wd;
      e.data   = exp_data;
      e.ctrl   = exp_ctrl;
      e.err    = exp_err;
      e.mis    = exp_mis;
      e.stalls = exp_stalls;
      sb.push_back(e);
      stalls = 0;
      reqs   = 0;
      done   = 0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(negedge clk);
         if (dmem_req) begin
            if (reqs == 0) begin
               checkOutput({tag, "_addr"}, dmem_addr, addr & ~32'h3);
               checkOutput({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
               checkOutput({tag, "_we"}, 32'(dmem_we), 32'(ctrl[4]));
               if (ctrl[4]) checkOutput({tag, "_wdata"}, dmem_wdata, exp_wdata);
            end
            dmem_ack   = (reqs == waits);
            dmem_rdata = (reqs == waits) ? rd : ~rd;
            reqs++;
         end else begin
            dmem_ack = 1'b0;
         end
         if (stall_m) begin
            stalls++;
         end else begin
            done = 1;
            e = sb.pop_front();
            checkOutput({tag, "_data"}, mem_read_data_m, e.data);
            checkOutput({tag, "_ctrl"}, 32'(control_m_o), 32'(e.ctrl));
            checkOutput({tag, "_err"}, 32'(bus_err_m), 32'(e.err));
            checkOutput({tag, "_mis"}, 32'(misalign_m), 32'(e.mis));
            checkOutput({tag, "_stalls"}, 32'(stalls), 32'(e.stalls));
            checkOutput({tag, "_reqoff"}, 32'(dmem_req), 32'h0);
         end
      end
      if (!done) checkOutput({tag, "_hang"}, 32'(stall_m), 32'h0);
   endtask

   task automatic idleCycle();
      @(posedge clk);
      #1;
      valid_m     = 1'b0;
      control_m_i = 7'b0;
   endtask

   logic [31:0] lane_word;
   logic [31:0] lane_exp [4];
   int          seen;

   initial begin
      rst              = 1'b1;
      valid_m          = 1'b1;
      control_m_i      = 7'b1101100;
      alu_result_m     = 32'h100;
      mem_write_data_m = 32'h0;
      dmem_rdata       = 32'h0;
      dmem_ack         = 1'b0;
      #12;
      checkOutput("rst_stall", 32'(stall_m), 32'h0);
      checkOutput("rst_req", 32'(dmem_req), 32'h0);
      checkOutput("rst_data", mem_read_data_m, 32'h0);
      checkOutput("rst_err", 32'(bus_err_m), 32'h0);
      valid_m = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      applyStimulus("ld_word", 1, 7'b1101100, 32'h100, 32'h0, 32'hDEADBEEF, 0,
                    32'hDEADBEEF, 2'b11, 0, 0, 2, 4'b1111, 32'h0);
      applyStimulus("ld_sbyte", 1, 7'b1101000, 32'h103, 32'h0, 32'h80FF0000, 0,
                    32'hFFFFFF80, 2'b11, 0, 0, 2, 4'b1000, 32'h0);
      applyStimulus("ld_ubyte", 1, 7'b1101001, 32'h103, 32'h0, 32'h80FF0000, 0,
                    32'h00000080, 2'b11, 0, 0, 2, 4'b1000, 32'h0);
      applyStimulus("st_half", 1, 7'b0010010, 32'h22, 32'h0000ABCD, 32'h0, 0,
                    32'h0, 2'b00, 0, 0, 2, 4'b1100, 32'hABCDABCD);
      applyStimulus("st_byte", 1, 7'b0010000, 32'h21, 32'h00000055, 32'h0, 1,
                    32'h0, 2'b00, 0, 0, 3, 4'b0010, 32'h55555555);
      applyStimulus("ld_shalf", 1, 7'b1101010, 32'h102, 32'h0, 32'h80011234, 2,
                    32'hFFFF8001, 2'b11, 0, 0, 4, 4'b1100, 32'h0);
      applyStimulus("ld_uhalf", 1, 7'b1101011, 32'h100, 32'h0, 32'h80011234, 0,
                    32'h00001234, 2'b11, 0, 0, 2, 4'b0011, 32'h0);
      applyStimulus("st_word_lastack", 1, 7'b0010100, 32'h104, 32'h12345678, 32'h0, 3,
                    32'h0, 2'b00, 0, 0, 5, 4'b1111, 32'h12345678);
      applyStimulus("st_prio", 1, 7'b0011000, 32'h13A, 32'h000000C3, 32'h0, 0,
                    32'h0, 2'b00, 0, 0, 2, 4'b0100, 32'hC3C3C3C3);

      lane_word   = 32'hF1728304;
      lane_exp[0] = 32'h00000004;
      lane_exp[1] = 32'hFFFFFF83;
      lane_exp[2] = 32'h00000072;
      lane_exp[3] = 32'hFFFFFFF1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus($sformatf("ld_lane%0d", i), 1, 7'b1101000, 32'h400 + 32'(i), 32'h0,
                       lane_word, i % 2, lane_exp[i], 2'b11, 0, 0, 2 + (i % 2),
                       4'b0001 << i, 32'h0);
      end

      applyStimulus("mis_word", 1, 7'b1101100, 32'h102, 32'h0, 32'h0, 0,
                    32'h0, 2'b01, 0, 1, 0, 4'b0000, 32'h0);
      applyStimulus("mis_half", 1, 7'b1101010, 32'h101, 32'h0, 32'h0, 0,
                    32'h0, 2'b01, 0, 1, 0, 4'b0000, 32'h0);
      applyStimulus("mis_size3", 1, 7'b1101110, 32'h100, 32'h0, 32'h0, 0,
                    32'h0, 2'b01, 0, 1, 0, 4'b0000, 32'h0);
      applyStimulus("alu_pass", 1, 7'b1100000, 32'h3, 32'h0, 32'h0, 0,
                    32'h0, 2'b11, 0, 0, 0, 4'b0000, 32'h0);
      applyStimulus("bubble", 0, 7'b1101100, 32'h102, 32'h0, 32'h0, 0,
                    32'h0, 2'b11, 0, 0, 0, 4'b0000, 32'h0);

      applyStimulus("timeout", 1, 7'b1101100, 32'h200, 32'h0, 32'h11111111, 99,
                    32'h0, 2'b01, 1, 0, 5, 4'b1111, 32'h0);
      idleCycle();
      @(negedge clk);
      @(negedge clk);
      dmem_rdata = 32'h11111111;
      dmem_ack   = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
      checkOutput("late_ack_req", 32'(dmem_req), 32'h0);
      checkOutput("late_ack_stall", 32'(stall_m), 32'h0);
      checkOutput("late_ack_data", mem_read_data_m, 32'h0);
      checkOutput("late_ack_err", 32'(bus_err_m), 32'h0);

      @(posedge clk);
      #1;
      valid_m      = 1'b1;
      control_m_i  = 7'b1101100;
      alu_result_m = 32'h300;
      seen         = 0;
      for (int cyc = 0; cyc < 20 && seen < 2; cyc++) begin
         @(negedge clk);
         if (dmem_req) seen++;
      end
      checkOutput("rst_mid_reqseen", 32'(seen), 32'd2);
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_req", 32'(dmem_req), 32'h0);
      checkOutput("rst_mid_stall", 32'(stall_m), 32'h0);
      valid_m = 1'b0;
      @(negedge clk);
      rst        = 1'b0;
      dmem_rdata = 32'h77777777;
      dmem_ack   = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
      checkOutput("post_rst_req", 32'(dmem_req), 32'h0);
      checkOutput("post_rst_data", mem_read_data_m, 32'h0);

      applyStimulus("ld_wait3", 1, 7'b1101100, 32'h300, 32'h0, 32'hCAFEF00D, 3,
                    32'hCAFEF00D, 2'b11, 0, 0, 5, 4'b1111, 32'h0);
      idleCycle();
      @(negedge clk);
      checkOutput("final_idle", 32'(stall_m), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
